// File: rtl/core_pkg.sv
// Shared decode definitions: RV32I opcodes, immediate formats, format lookup.
package core_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_SYSTEM = 7'b1110011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_t;

  // Immediate format carried by an opcode; R-type and unknown opcodes have none.
  function automatic imm_type_t imm_type_of(input logic [OPCODE_W-1:0] op);
    imm_type_t t;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: t = IMM_I;
      OP_STORE:                            t = IMM_S;
      OP_BRANCH:                           t = IMM_B;
      OP_LUI, OP_AUIPC:                    t = IMM_U;
      OP_JAL:                              t = IMM_J;
      default:                             t = IMM_NONE;
    endcase
    return t;
  endfunction

  // An opcode is legal if it has an immediate format or is register-register.
  function automatic logic opcode_legal(input logic [OPCODE_W-1:0] op);
    return (imm_type_of(op) != IMM_NONE) || (op == OP_REG);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: format select, field assembly, extension.
module imm_gen
  import core_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [WIDTH-1:0]   imm,
  output logic               illegal
);

  imm_type_t         imm_type;
  logic [INSTR_W-1:0] raw;
  logic               sext;

  assign imm_type = imm_type_of(instr[6:0]);
  assign illegal  = !opcode_legal(instr[6:0]);

  // Assemble the 32-bit immediate; U-type is the only unsigned-extended format.
  always_comb begin
    raw  = '0;
    sext = 1'b0;
    case (imm_type)
      IMM_I: begin
        raw  = {{20{instr[31]}}, instr[31:20]};
        sext = 1'b1;
      end
      IMM_S: begin
        raw  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        sext = 1'b1;
      end
      IMM_B: begin
        raw  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        sext = 1'b1;
      end
      IMM_U: begin
        raw  = {instr[31:12], 12'b0};
      end
      IMM_J: begin
        raw  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        sext = 1'b1;
      end
      default: begin
        raw  = '0;
      end
    endcase
  end

  assign imm = sext ? WIDTH'($signed(raw)) : WIDTH'(raw);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage with ID/EX pipeline register (valid/ready, stall, flush).
// Optional writeback bypass into captured and held operands: DECODE_BYPASS_EN.
module decode_stage
  import core_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned REGISTERS = 32,
  parameter int unsigned ADDR_W    = $clog2(REGISTERS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [WIDTH-1:0]    in_pc,
  output logic [ADDR_W-1:0]   rf_a1,
  output logic [ADDR_W-1:0]   rf_a2,
  input  logic [WIDTH-1:0]    rf_rd1,
  input  logic [WIDTH-1:0]    rf_rd2,
  input  logic                wb_we,
  input  logic [ADDR_W-1:0]   wb_a3,
  input  logic [WIDTH-1:0]    wb_wd,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_pc,
  output logic [WIDTH-1:0]    out_rs1_val,
  output logic [WIDTH-1:0]    out_rs2_val,
  output logic [WIDTH-1:0]    out_imm,
  output logic [ADDR_W-1:0]   out_rs1,
  output logic [ADDR_W-1:0]   out_rs2,
  output logic [ADDR_W-1:0]   out_rd,
  output logic [6:0]          out_opcode,
  output logic [2:0]          out_funct3,
  output logic [6:0]          out_funct7,
  output logic                out_illegal
);

  logic [ADDR_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [WIDTH-1:0]  rs1_val, rs2_val;
  logic [WIDTH-1:0]  imm;
  logic              illegal;
  logic              capture;

  logic              valid_q,   valid_d;
  logic [WIDTH-1:0]  pc_q,      pc_d;
  logic [WIDTH-1:0]  rs1_val_q, rs1_val_d;
  logic [WIDTH-1:0]  rs2_val_q, rs2_val_d;
  logic [WIDTH-1:0]  imm_q,     imm_d;
  logic [ADDR_W-1:0] rs1_q,     rs1_d;
  logic [ADDR_W-1:0] rs2_q,     rs2_d;
  logic [ADDR_W-1:0] rd_q,      rd_d;
  logic [6:0]        opcode_q,  opcode_d;
  logic [2:0]        funct3_q,  funct3_d;
  logic [6:0]        funct7_q,  funct7_d;
  logic              illegal_q, illegal_d;

  assign rs1_idx = ADDR_W'(in_instr[19:15]);
  assign rs2_idx = ADDR_W'(in_instr[24:20]);
  assign rd_idx  = ADDR_W'(in_instr[11:7]);
  assign rf_a1   = rs1_idx;
  assign rf_a2   = rs2_idx;

  assign in_ready = !flush && (!valid_q || out_ready);
  assign capture  = in_valid && in_ready;

  imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
    .instr   (in_instr),
    .imm     (imm),
    .illegal (illegal)
  );

`ifdef DECODE_BYPASS_EN
  // Operand select at capture: x0 forced to zero, same-cycle writeback wins.
  always_comb begin
    rs1_val = rf_rd1;
    rs2_val = rf_rd2;
    if (wb_we && (wb_a3 == rs1_idx)) rs1_val = wb_wd;
    if (wb_we && (wb_a3 == rs2_idx)) rs2_val = wb_wd;
    if (rs1_idx == '0) rs1_val = '0;
    if (rs2_idx == '0) rs2_val = '0;
  end
`else
  // Operand select at capture: x0 forced to zero, register file data otherwise.
  always_comb begin
    rs1_val = (rs1_idx == '0) ? '0 : rf_rd1;
    rs2_val = (rs2_idx == '0) ? '0 : rf_rd2;
  end

  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_a3, wb_wd};
`endif

  // ID/EX next state: flush beats capture, capture beats consume/stall.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d   = 1'b1;
      pc_d      = in_pc;
      rs1_val_d = rs1_val;
      rs2_val_d = rs2_val;
      imm_d     = imm;
      rs1_d     = rs1_idx;
      rs2_d     = rs2_idx;
      rd_d      = rd_idx;
      opcode_d  = in_instr[6:0];
      funct3_d  = in_instr[14:12];
      funct7_d  = in_instr[31:25];
      illegal_d = illegal;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
`ifdef DECODE_BYPASS_EN
    else if (valid_q) begin
      if (wb_we && (wb_a3 == rs1_q) && (rs1_q != '0)) rs1_val_d = wb_wd;
      if (wb_we && (wb_a3 == rs2_q) && (rs2_q != '0)) rs2_val_d = wb_wd;
    end
`endif
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      imm_q     <= imm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_rs1_val = rs1_val_q;
  assign out_rs2_val = rs2_val_q;
  assign out_imm     = imm_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_rd      = rd_q;
  assign out_opcode  = opcode_q;
  assign out_funct3  = funct3_q;
  assign out_funct7  = funct7_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage; expectations follow DECODE_BYPASS_EN.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rf_a1       (rf_a1),
    .rf_a2       (rf_a2),
    .rf_rd1      (rf_rd1),
    .rf_rd2      (rf_rd2),
    .wb_we       (wb_we),
    .wb_a3       (wb_a3),
    .wb_wd       (wb_wd),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_rs1_val (out_rs1_val),
    .out_rs2_val (out_rs2_val),
    .out_imm     (out_imm),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_opcode  (out_opcode),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7),
    .out_illegal (out_illegal)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rd1, input logic [31:0] rd2);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    rf_rd1   = rd1;
    rf_rd2   = rd2;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; rf_rd1 = '0; rf_rd2 = '0;
    wb_we = 1'b0; wb_a3 = '0; wb_wd = '0; flush = 1'b0; out_ready = 1'b1;
    tick; tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_imm !== 32'h0) begin n_fail++; $display("FAIL reset_imm: got %h want 0", out_imm); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", out_illegal); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_addi;
    out_ready = 1'b1;
    drive(32'hFFF50293, 32'h100, 32'h10, 32'h99);
    #1;
    n_checks++; if (rf_a1 !== 5'd10) begin n_fail++; $display("FAIL addi_rf_a1: got %0d want 10", rf_a1); end
    n_checks++; if (rf_a2 !== 5'd31) begin n_fail++; $display("FAIL addi_rf_a2: got %0d want 31", rf_a2); end
    tick;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    n_checks++; if (out_rd !== 5'd5) begin n_fail++; $display("FAIL addi_rd: got %0d want 5", out_rd); end
    n_checks++; if (out_imm !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL addi_imm: got %h want ffffffff", out_imm); end
    n_checks++; if (out_rs1_val !== 32'h10) begin n_fail++; $display("FAIL addi_rs1_val: got %h want 10", out_rs1_val); end
    n_checks++; if (out_rs2_val !== 32'h99) begin n_fail++; $display("FAIL addi_rs2_val: got %h want 99", out_rs2_val); end
    n_checks++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL addi_pc: got %h want 100", out_pc); end
    n_checks++; if (out_opcode !== 7'h13) begin n_fail++; $display("FAIL addi_opcode: got %h want 13", out_opcode); end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    drive(32'hFEB52E23, 32'h104, 32'h20, 32'h30);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_checks++; if (out_pc !== 32'h100 || out_imm !== 32'hFFFFFFFF || out_valid !== 1'b1)
        begin n_fail++; $display("FAIL stall_hold[%0d]: got pc %h imm %h v %b want 100 ffffffff 1", i, out_pc, out_imm, out_valid); end
      tick;
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    n_checks++; if (out_pc !== 32'h104) begin n_fail++; $display("FAIL sw_pc: got %h want 104", out_pc); end
    n_checks++; if (out_imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL sw_imm: got %h want fffffffc", out_imm); end
    n_checks++; if (out_rs2 !== 5'd11 || out_rs2_val !== 32'h30) begin n_fail++; $display("FAIL sw_rs2: got %0d/%h want 11/30", out_rs2, out_rs2_val); end
    n_checks++; if (out_rs1 !== 5'd10 || out_rs1_val !== 32'h20) begin n_fail++; $display("FAIL sw_rs1: got %0d/%h want 10/20", out_rs1, out_rs1_val); end
  endtask

  // Back-to-back decode of every immediate format plus an illegal opcode.
  task automatic test_imm_decode;
    logic [31:0] v_instr [7] = '{32'h00B50463, 32'hABCDE0B7, 32'hFFDFF06F, 32'h12345297,
                                 32'h00412303, 32'h402081B3, 32'h0000007F};
    logic [31:0] v_imm   [7] = '{32'h00000008, 32'hABCDE000, 32'hFFFFFFFC, 32'h12345000,
                                 32'h00000004, 32'h00000000, 32'h00000000};
    logic [2:0]  v_f3    [7] = '{3'd0, 3'd6, 3'd7, 3'd5, 3'd2, 3'd0, 3'd0};
    logic [6:0]  v_f7    [7] = '{7'h00, 7'h55, 7'h7F, 7'h09, 7'h00, 7'h20, 7'h00};
    logic        v_ill   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(v_instr[i], 32'h400 + 32'(i * 4), 32'h1, 32'h2);
      tick;
      n_checks++; if (out_imm !== v_imm[i]) begin n_fail++; $display("FAIL imm[%0d]: got %h want %h", i, out_imm, v_imm[i]); end
      n_checks++; if (out_illegal !== v_ill[i]) begin n_fail++; $display("FAIL illegal[%0d]: got %b want %b", i, out_illegal, v_ill[i]); end
      n_checks++; if (out_funct3 !== v_f3[i] || out_funct7 !== v_f7[i])
        begin n_fail++; $display("FAIL funct[%0d]: got %0d/%h want %0d/%h", i, out_funct3, out_funct7, v_f3[i], v_f7[i]); end
      n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h400 + 32'(i * 4))
        begin n_fail++; $display("FAIL b2b[%0d]: got v %b pc %h want 1 %h", i, out_valid, out_pc, 32'h400 + 32'(i * 4)); end
    end
    in_valid = 1'b0;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_bypass;
    logic [31:0] exp_cap, exp_hold;
`ifdef DECODE_BYPASS_EN
    exp_cap  = 32'h12345678;
    exp_hold = 32'hCAFEF00D;
`else
    exp_cap  = 32'h0;
    exp_hold = 32'h0;
`endif
    out_ready = 1'b1;
    drive(32'h00038093, 32'h500, 32'h0, 32'h77);
    wb_we = 1'b1; wb_a3 = 5'd7; wb_wd = 32'h12345678;
    tick;
    in_valid = 1'b0; wb_we = 1'b0;
    n_checks++; if (out_rs1_val !== exp_cap) begin n_fail++; $display("FAIL bypass_capture: got %h want %h", out_rs1_val, exp_cap); end
    n_checks++; if (out_rs2_val !== 32'h0) begin n_fail++; $display("FAIL bypass_rs2_x0: got %h want 0", out_rs2_val); end
    out_ready = 1'b0;
    wb_we = 1'b1; wb_a3 = 5'd7; wb_wd = 32'hCAFEF00D;
    tick;
    wb_we = 1'b0;
    n_checks++; if (out_rs1_val !== exp_hold) begin n_fail++; $display("FAIL bypass_stall: got %h want %h", out_rs1_val, exp_hold); end
    out_ready = 1'b1;
    tick;
  endtask

  task automatic test_x0;
    out_ready = 1'b1;
    drive(32'h00000093, 32'h600, 32'hABCDE123, 32'hABCDE123);
    wb_we = 1'b1; wb_a3 = 5'd0; wb_wd = 32'h55;
    tick;
    in_valid = 1'b0; wb_we = 1'b0;
    n_checks++; if (out_rs1_val !== 32'h0) begin n_fail++; $display("FAIL x0_rs1: got %h want 0", out_rs1_val); end
    n_checks++; if (out_rs2_val !== 32'h0) begin n_fail++; $display("FAIL x0_rs2: got %h want 0", out_rs2_val); end
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    drive(32'hFFF50293, 32'h700, 32'h1, 32'h1);
    tick;
    drive(32'h00412303, 32'h704, 32'h1, 32'h1);
    flush = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_checks++; if (out_pc !== 32'h700 || out_imm !== 32'hFFFFFFFF)
      begin n_fail++; $display("FAIL flush_data: got pc %h imm %h want 700 ffffffff", out_pc, out_imm); end
  endtask

  task automatic test_reset_stall;
    out_ready = 1'b1;
    drive(32'h00412303, 32'h800, 32'h3, 32'h4);
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0)
      begin n_fail++; $display("FAIL reset_stall: got v %b pc %h want 0 0", out_valid, out_pc); end
    tick;
    rst = 1'b0; out_ready = 1'b1;
    tick;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_addi;
    test_stall;
    test_imm_decode;
    test_bypass;
    test_x0;
    test_flush;
    test_reset_stall;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the pipelined core, sitting directly upstream of `register_file` and downstream of fetch. Splits each fetched RV32I instruction into fields, drives the register file read addresses, captures `rd1`/`rd2`, generates the sign-extended immediate, and holds everything in the ID/EX pipeline register. The ID/EX register uses a valid/ready handshake with stall and flush. An optional writeback bypass is provided.

## Interface
Parameters:
- `WIDTH`, 32, datapath and register width (matches `register_file`).
- `REGISTERS`, 32, register count.
- `ADDR_W`, `$clog2(REGISTERS)`, register address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  WIDTH  PC of `in_instr`.
- `rf_a1`  out  ADDR_W  to `register_file.a1`, equal to `in_instr[19:15]`.
- `rf_a2`  out  ADDR_W  to `register_file.a2`, equal to `in_instr[24:20]`.
- `rf_rd1`, `rf_rd2`  in  WIDTH  combinational read data from `register_file`.
- `wb_we`  in  1  copy of the register file write enable (`we3`).
- `wb_a3`  in  ADDR_W  copy of the register file write address (`a3`).
- `wb_wd`  in  WIDTH  copy of the register file write data (`wd3`).
- `flush`  in  1  kill the decoded instruction (branch or exception).
- `out_valid`  out  1  ID/EX holds a valid instruction.
- `out_ready`  in  1  execute consumes the held instruction.
- `out_pc`, `out_rs1_val`, `out_rs2_val`, `out_imm`  out  WIDTH  registered PC, operands and immediate.
- `out_rs1`, `out_rs2`, `out_rd`  out  ADDR_W  registered register indices.
- `out_opcode`  out  7  registered opcode.
- `out_funct3`  out  3  registered funct3.
- `out_funct7`  out  7  registered funct7.
- `out_illegal`  out  1  registered illegal-opcode flag.

## Operation
- `rf_a1` and `rf_a2` are combinational from `in_instr` and are not reset.
- Ready rule: `in_ready = !flush && (!out_valid || out_ready)`.
- Capture: when `in_valid && in_ready`, all `out_*` load and `out_valid` is set to 1.
- Consume: when `out_ready` is high and there is no capture, `out_valid` is cleared to 0.
- Flush: `flush` has priority over capture and stall. On the next edge `out_valid` is 0 and the data registers are left unchanged.
- x0: an operand whose source index is 0 is forced to 0, regardless of `rf_rd*` or bypass.
- Immediate by opcode:
  - I-type (`0010011`, `0000011`, `1100111`, `1110011`): `instr[31:20]`.
  - S-type (`0100011`): `{instr[31:25], instr[11:7]}`.
  - B-type (`1100011`): `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U-type (`0110111`, `0010111`): `{instr[31:12], 12'b0}`.
  - J-type (`1101111`): `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - R-type (`0110011`): immediate is 0.
  - All I/S/B/J immediates are sign-extended from `instr[31]` to WIDTH.
- Any other opcode: `out_illegal` is 1 and `out_imm` is 0. The instruction still flows with `out_valid` set.

## Timing
- Latency is one cycle from accepted input to `out_valid`.
- Throughput is one instruction per cycle when `out_ready` is held high.
- Reset value of every registered output is 0, including `out_valid`.
- Reset mid-stall drops the held instruction.
- `register_file` writes on the rising edge. A write and a read of the same register in the same cycle therefore returns the old value, unless the bypass is compiled in.
- Stalled stage (`out_valid && !out_ready`): the held outputs are stable.

## Configuration
- `DECODE_BYPASS_EN` defined:
  - On capture, if `wb_we && wb_a3 == rs && rs != 0`, the operand takes `wb_wd` instead of `rf_rd*`.
  - While stalled, if `wb_we && wb_a3 == out_rs1` (or `out_rs2`) and the index is non-zero, `out_rs1_val` (or `out_rs2_val`) updates to `wb_wd`, so a held operand never goes stale.
- `DECODE_BYPASS_EN` undefined: operands come only from `rf_rd*` at capture and are never updated while stalled. The hazard unit must insert a bubble in this case.

## Structure
- `core_pkg` holds:
  - opcode localparams (`OP_IMM`, `OP_LOAD`, `OP_JALR`, `OP_SYSTEM`, `OP_STORE`, `OP_BRANCH`, `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_REG`);
  - the enum `imm_type_t` (`IMM_I`, `IMM_S`, `IMM_B`, `IMM_U`, `IMM_J`, `IMM_NONE`).
- Sub-module `imm_gen` is purely combinational: input `instr`, outputs `imm` and `illegal`.

## Test plan
- Reset, then accept `addi x5, x10, -1` (`0xFFF50293`) with `rf_rd1 = 0x10` -> one cycle later `out_valid = 1`, `out_rd = 5`, `out_imm = 0xFFFFFFFF`, `out_rs1_val = 0x10`.
- Hold `out_ready = 0` with `in_valid = 1` for 3 cycles -> `in_ready = 0` and outputs unchanged. Release `out_ready` -> the next instruction is captured the following edge.
- Decode `sw` `0xFEB52E23` -> `out_imm = 0xFFFFFFFC`. Decode `beq` `0x00B50463` -> `out_imm = 8`. Decode `lui` `0xABCDE0B7` -> `out_imm = 0xABCDE000`.
- Same cycle `wb_we = 1`, `wb_a3 = 7`, `wb_wd = 0x12345678`, instruction reads x7 with `rf_rd1 = 0`:
  - bypass defined -> `out_rs1_val = 0x12345678`;
  - bypass undefined -> `out_rs1_val = 0`.
- Instruction reading x0 with `rf_rd1 = 0xABCDE123` and a concurrent write to x0 -> `out_rs1_val = 0`.
- `flush` asserted in the same cycle as a valid input -> next cycle `out_valid = 0`. Opcode `0x7F` -> `out_illegal = 1`, `out_imm = 0`.
